// File: rtl/vc_domain_pipe_reg_pkg.sv
// ---------------------------------------------------------------------------
// vc_domain_pipe_reg_pkg
//   Shared definitions for the domain-tagged elastic register chain.
//   - DOMAIN_L / DOMAIN_H : 1-bit security domain encodings
//   - dom_match()         : decode of "this entry is scrubbed by the flush"
// ---------------------------------------------------------------------------
package vc_domain_pipe_reg_pkg;

  localparam logic DOMAIN_L = 1'b0;
  localparam logic DOMAIN_H = 1'b1;

  // True when a flush is active and the entry's tag selects the flushed domain.
  function automatic logic dom_match(input logic flush,
                                     input logic dom,
                                     input logic flush_domain);
    return flush && ((dom == DOMAIN_H) == (flush_domain == DOMAIN_H));
  endfunction

endpackage

// File: rtl/vc_domain_pipe_stage.sv
// ---------------------------------------------------------------------------
// vc_domain_pipe_stage
//   One slot of the elastic chain: valid bit, domain tag and data word.
//   Ports:
//     clk, reset      : clock, synchronous active-low reset
//     up_load         : upstream entry transfers into this slot this cycle
//     up_dom, up_data : tag and data of the upstream entry
//     dn_ready        : the slot downstream can take our entry this cycle
//     kill            : this slot's entry belongs to the domain being flushed
//     val, dom, data  : registered slot contents
//     adv             : our entry moves downstream this cycle
// ---------------------------------------------------------------------------
module vc_domain_pipe_stage
  import vc_domain_pipe_reg_pkg::*;
#(
  parameter int                 p_nbits       = 32,
  parameter logic [p_nbits-1:0] p_reset_value = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               up_load,
  input  logic               up_dom,
  input  logic [p_nbits-1:0] up_data,
  input  logic               dn_ready,
  input  logic               kill,
  output logic               val,
  output logic               dom,
  output logic [p_nbits-1:0] data,
  output logic               adv
);

  // A killed entry is never handed downstream.
  assign adv = val && !kill && dn_ready;

  // A refill from upstream wins over a kill: the killed slot is vacated and
  // may be reoccupied by the other domain in the same cycle. A slot that is
  // only advanced keeps its stale data; only a kill scrubs it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      val  <= 1'b0;
      dom  <= DOMAIN_L;
      data <= p_reset_value;
    end else if (up_load) begin
      val  <= 1'b1;
      dom  <= up_dom;
      data <= up_data;
    end else if (kill) begin
      val  <= 1'b0;
      dom  <= DOMAIN_L;
      data <= p_reset_value;
    end else if (adv) begin
      val  <= 1'b0;
    end
  end

endmodule

// File: rtl/vc_domain_pipe_reg.sv
// ---------------------------------------------------------------------------
// vc_domain_pipe_reg
//   Elastic p_depth-stage register chain with val/rdy handshake at each end.
//   Every entry carries a 1-bit domain tag; flush scrubs all entries of
//   flush_domain in the same cycle.
//   Ports:
//     clk, reset                   : clock, synchronous active-low reset
//     in_val, in_rdy               : producer handshake
//     in_domain, in_msg            : tag and message of the producer entry
//     out_val, out_rdy             : consumer handshake
//     out_domain, out_msg          : last-stage tag and data (qualify w/ out_val)
//     flush, flush_domain          : scrub request and domain to scrub
//     occupancy                    : registered count of valid stages
// ---------------------------------------------------------------------------
module vc_domain_pipe_reg
  import vc_domain_pipe_reg_pkg::*;
#(
  parameter int                 p_nbits       = 32,
  parameter int                 p_depth       = 2,
  parameter logic [p_nbits-1:0] p_reset_value = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_val,
  output logic                         in_rdy,
  input  logic                         in_domain,
  input  logic [p_nbits-1:0]           in_msg,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic                         out_domain,
  output logic [p_nbits-1:0]           out_msg,
  input  logic                         flush,
  input  logic                         flush_domain,
  output logic [$clog2(p_depth+1)-1:0] occupancy
);

  localparam int LAST  = p_depth - 1;
  localparam int OCC_W = $clog2(p_depth + 1);

  logic [p_depth-1:0] val, dom, kill, ev, ready, adv, load, val_nxt;
  logic [p_nbits-1:0] data [p_depth];
  logic               in_kill;
  logic [OCC_W-1:0]   occ_nxt;

  // ev = entry that survives this cycle's flush
  always_comb begin
    kill = '0;
    ev   = '0;
    for (int i = 0; i < p_depth; i++) begin
      kill[i] = dom_match(flush, dom[i], flush_domain);
      ev[i]   = val[i] && !kill[i];
    end
  end

  // Ready chain, evaluated from the output back to the input. A slot is
  // ready for its upstream neighbour when it is empty after kills or its own
  // entry moves on, which gives full throughput across the whole chain.
  always_comb begin
    ready       = '0;
    ready[LAST] = out_rdy;
    for (int i = LAST - 1; i >= 0; i--) begin
      ready[i] = !ev[i+1] || ready[i+1];
    end
  end

  assign in_rdy  = !ev[0] || ready[0];
  // A producer entry of the flushed domain is handshaken but dropped.
  assign in_kill = dom_match(flush, in_domain, flush_domain);

  for (genvar i = 0; i < p_depth; i++) begin : g_stage
    logic               up_dom_i;
    logic [p_nbits-1:0] up_data_i;

    if (i == 0) begin : g_head
      assign load[i]   = in_val && in_rdy && !in_kill;
      assign up_dom_i  = in_domain;
      assign up_data_i = in_msg;
    end else begin : g_body
      assign load[i]   = adv[i-1];
      assign up_dom_i  = dom[i-1];
      assign up_data_i = data[i-1];
    end

    vc_domain_pipe_stage #(
      .p_nbits       (p_nbits),
      .p_reset_value (p_reset_value)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .up_load  (load[i]),
      .up_dom   (up_dom_i),
      .up_data  (up_data_i),
      .dn_ready (ready[i]),
      .kill     (kill[i]),
      .val      (val[i]),
      .dom      (dom[i]),
      .data     (data[i]),
      .adv      (adv[i])
    );
  end

  assign out_val    = ev[LAST];
  assign out_domain = dom[LAST];
  assign out_msg    = data[LAST];

  // Occupancy tracks the valid bits as they will be after this edge.
  always_comb begin
    val_nxt = '0;
    occ_nxt = '0;
    for (int i = 0; i < p_depth; i++) begin
      val_nxt[i] = load[i] || (val[i] && !adv[i] && !kill[i]);
      occ_nxt    = occ_nxt + OCC_W'(val_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) occupancy <= '0;
    else        occupancy <= occ_nxt;
  end

endmodule

// File: tb/tb_vc_domain_pipe_reg.sv
module tb_vc_domain_pipe_reg;

  localparam int W = 32;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_val = 1'b0, in_domain = 1'b0, out_rdy = 1'b0;
  logic         flush = 1'b0, flush_domain = 1'b0;
  logic [W-1:0] in_msg = '0;
  logic         in_rdy, out_val, out_domain;
  logic [W-1:0] out_msg;
  logic [1:0]   occupancy;

  vc_domain_pipe_reg #(.p_nbits(W), .p_depth(D), .p_reset_value('0)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_val       (in_val),
    .in_rdy       (in_rdy),
    .in_domain    (in_domain),
    .in_msg       (in_msg),
    .out_val      (out_val),
    .out_rdy      (out_rdy),
    .out_domain   (out_domain),
    .out_msg      (out_msg),
    .flush        (flush),
    .flush_domain (flush_domain),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  // Reference model: ordered list of live entries. age counts edges since
  // acceptance; with two stages the oldest entry is deliverable once it has
  // spent at least one edge in the chain.
  typedef struct {
    logic         dom;
    logic [W-1:0] data;
    int           age;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;

  logic         s_in_rdy, s_out_val, s_out_dom;
  logic [W-1:0] s_out_msg;
  logic [1:0]   s_occ;
  logic         e_in_rdy, e_out_val, e_out_dom;
  logic [W-1:0] e_out_msg;
  int           e_occ;

  // Drive one cycle, sample DUT before and after the edge, advance the model.
  task automatic step(input logic iv, input logic idom, input logic [W-1:0] imsg,
                      input logic ordy, input logic fl, input logic fd);
    ent_t nq[$];
    int   live;
    @(negedge clk);
    in_val = iv; in_domain = idom; in_msg = imsg;
    out_rdy = ordy; flush = fl; flush_domain = fd;
    #1;
    live = 0;
    foreach (q[k]) if (!(fl && q[k].dom == fd)) live++;
    e_out_val = (q.size() > 0) && (q[0].age >= 1) && !(fl && q[0].dom == fd);
    e_out_msg = (q.size() > 0) ? q[0].data : '0;
    e_out_dom = (q.size() > 0) ? q[0].dom : 1'b0;
    e_in_rdy  = !(live == D && !ordy);
    s_in_rdy  = in_rdy;
    s_out_val = out_val;
    s_out_msg = out_msg;
    s_out_dom = out_domain;
    @(posedge clk);
    #1;
    nq = {};
    foreach (q[k]) begin
      if (!(fl && q[k].dom == fd)) begin
        ent_t e;
        e = q[k];
        e.age++;
        nq.push_back(e);
      end
    end
    if (e_out_val && ordy) void'(nq.pop_front());
    if (iv && e_in_rdy && !(fl && idom == fd)) nq.push_back('{idom, imsg, 0});
    q = nq;
    e_occ = q.size();
    s_occ = occupancy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_val = 1'b0; out_rdy = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    q.delete();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL reset_out_val got=%b want=0", out_val); end
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL reset_in_rdy got=%b want=1", in_rdy); end
    total++; if (out_msg !== 32'h0) begin bad++; $display("FAIL reset_out_msg got=%h want=0", out_msg); end
    total++; if (out_domain !== 1'b0) begin bad++; $display("FAIL reset_out_dom got=%b want=0", out_domain); end
  endtask

  task automatic test_stream();
    logic [W-1:0] want [5];
    logic         wval [5];
    int           wocc [5];
    want = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33};
    wval = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    wocc = '{1, 2, 2, 1, 0};
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      step(1'b1, 1'b0, 32'h11, 1'b1, 1'b0, 1'b0);
      else if (c == 1) step(1'b1, 1'b0, 32'h22, 1'b1, 1'b0, 1'b0);
      else if (c == 2) step(1'b1, 1'b0, 32'h33, 1'b1, 1'b0, 1'b0);
      else             step(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0);
      total++; if (s_out_val !== wval[c]) begin bad++; $display("FAIL stream_val c=%0d got=%b want=%b", c, s_out_val, wval[c]); end
      if (wval[c]) begin
        total++; if (s_out_msg !== want[c]) begin bad++; $display("FAIL stream_msg c=%0d got=%h want=%h", c, s_out_msg, want[c]); end
      end
      total++; if (s_in_rdy !== 1'b1) begin bad++; $display("FAIL stream_in_rdy c=%0d got=%b want=1", c, s_in_rdy); end
      total++; if (int'(s_occ) != wocc[c]) begin bad++; $display("FAIL stream_occ c=%0d got=%0d want=%0d", c, s_occ, wocc[c]); end
    end
  endtask

  task automatic test_backpressure();
    step(1'b1, 1'b0, 32'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'hB, 1'b0, 1'b0, 1'b0);
    total++; if (s_occ !== 2'd2) begin bad++; $display("FAIL bp_fill_occ got=%0d want=2", s_occ); end
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b0, 32'hDEAD, 1'b0, 1'b0, 1'b0);
      total++; if (s_in_rdy !== 1'b0) begin bad++; $display("FAIL bp_in_rdy c=%0d got=%b want=0", c, s_in_rdy); end
      total++; if (s_out_val !== 1'b1 || s_out_msg !== 32'hA) begin bad++; $display("FAIL bp_hold c=%0d got=%b/%h want=1/a", c, s_out_val, s_out_msg); end
      total++; if (s_occ !== 2'd2) begin bad++; $display("FAIL bp_occ c=%0d got=%0d want=2", c, s_occ); end
    end
    // Full chain with the consumer ready still takes a new entry.
    step(1'b1, 1'b0, 32'hC, 1'b1, 1'b0, 1'b0);
    total++; if (s_in_rdy !== 1'b1) begin bad++; $display("FAIL bp_full_accept got=%b want=1", s_in_rdy); end
    total++; if (s_out_val !== 1'b1 || s_out_msg !== 32'hA) begin bad++; $display("FAIL bp_drain0 got=%b/%h want=1/a", s_out_val, s_out_msg); end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    total++; if (s_out_val !== 1'b1 || s_out_msg !== 32'hB) begin bad++; $display("FAIL bp_drain1 got=%b/%h want=1/b", s_out_val, s_out_msg); end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    total++; if (s_out_val !== 1'b1 || s_out_msg !== 32'hC) begin bad++; $display("FAIL bp_drain2 got=%b/%h want=1/c", s_out_val, s_out_msg); end
    total++; if (s_occ !== 2'd0) begin bad++; $display("FAIL bp_empty_occ got=%0d want=0", s_occ); end
  endtask

  task automatic test_flush_other_domain();
    step(1'b1, 1'b0, 32'h6, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    total++; if (s_out_val !== 1'b1 || s_out_msg !== 32'h6) begin bad++; $display("FAIL fl_keep got=%b/%h want=1/6", s_out_val, s_out_msg); end
    total++; if (s_in_rdy !== 1'b1) begin bad++; $display("FAIL fl_in_rdy got=%b want=1", s_in_rdy); end
    total++; if (s_occ !== 2'd1) begin bad++; $display("FAIL fl_occ got=%0d want=1", s_occ); end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    total++; if (s_out_val !== 1'b1 || s_out_msg !== 32'h6 || s_out_dom !== 1'b0) begin bad++; $display("FAIL fl_deliver got=%b/%h/%b want=1/6/0", s_out_val, s_out_msg, s_out_dom); end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    total++; if (s_out_val !== 1'b0 || s_occ !== 2'd0) begin bad++; $display("FAIL fl_gone got=%b/%0d want=0/0", s_out_val, s_occ); end
  endtask

  task automatic test_flush_last();
    step(1'b1, 1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1);
    total++; if (s_out_val !== 1'b0) begin bad++; $display("FAIL fl_last_val got=%b want=0", s_out_val); end
    total++; if (s_occ !== 2'd0) begin bad++; $display("FAIL fl_last_occ got=%0d want=0", s_occ); end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    total++; if (s_out_val !== 1'b0) begin bad++; $display("FAIL fl_last_after got=%b want=0", s_out_val); end
  endtask

  task automatic test_flush_input();
    step(1'b1, 1'b1, 32'h99, 1'b1, 1'b1, 1'b1);
    total++; if (s_in_rdy !== 1'b1) begin bad++; $display("FAIL fl_in_rdy got=%b want=1", s_in_rdy); end
    total++; if (s_occ !== 2'd0) begin bad++; $display("FAIL fl_in_occ got=%0d want=0", s_occ); end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    total++; if (s_out_val !== 1'b0) begin bad++; $display("FAIL fl_in_dropped got=%b want=0", s_out_val); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 5) == 0), 1'($urandom));
      total++; if (s_in_rdy !== e_in_rdy) begin bad++; $display("FAIL rnd_in_rdy c=%0d got=%b want=%b", c, s_in_rdy, e_in_rdy); end
      total++; if (s_out_val !== e_out_val) begin bad++; $display("FAIL rnd_out_val c=%0d got=%b want=%b", c, s_out_val, e_out_val); end
      if (e_out_val) begin
        total++; if (s_out_msg !== e_out_msg || s_out_dom !== e_out_dom) begin bad++; $display("FAIL rnd_out c=%0d got=%h/%b want=%h/%b", c, s_out_msg, s_out_dom, e_out_msg, e_out_dom); end
      end
      total++; if (int'(s_occ) != e_occ) begin bad++; $display("FAIL rnd_occ c=%0d got=%0d want=%0d", c, s_occ, e_occ); end
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b1, 1'b0, 32'h1234, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h5678, 1'b0, 1'b0, 1'b0);
    total++; if (s_occ !== 2'd2) begin bad++; $display("FAIL mr_full got=%0d want=2", s_occ); end
    @(negedge clk);
    reset = 1'b0; in_val = 1'b1; in_msg = 32'hEE; out_rdy = 1'b1; flush = 1'b1; flush_domain = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL mr_occ got=%0d want=0", occupancy); end
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL mr_out_val got=%b want=0", out_val); end
    total++; if (out_msg !== 32'h0) begin bad++; $display("FAIL mr_out_msg got=%h want=0", out_msg); end
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL mr_in_rdy got=%b want=1", in_rdy); end
    reset = 1'b1; in_val = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_other_domain();
    test_flush_last();
    test_flush_input();
    test_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vc_domain_pipe_reg.md
# vc_domain_pipe_reg

Parametrised elastic pipeline register chain: the next generation of the single-stage `vc_Reg`/`vc_EnResetReg` family. It carries a p_nbits message through p_depth stages with a val/rdy handshake at each end. Every entry is tagged with a 1-bit security domain, and a flush command scrubs all entries of one domain. It sits between producer/consumer pipeline blocks whose data must not cross a domain switch.

## Interface
Parameters:
- p_nbits, 32, message width
- p_depth, 2, number of stages (≥1)
- p_reset_value, 0, value loaded into every data register on reset and on scrub

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  reset, synchronous, active-low
- in_val  input  1  producer has a message
- in_rdy  output  1  chain can accept this cycle
- in_domain  input  1  domain tag of in_msg; labels in_msg
- in_msg  input  p_nbits  message, label {Data in_domain}
- out_val  output  1  last stage holds a deliverable message
- out_rdy  input  1  consumer accepts
- out_domain  output  1  tag of last stage
- out_msg  output  p_nbits  last-stage data, label {Data out_domain}
- flush  input  1  scrub request, control-level label
- flush_domain  input  1  domain to scrub
- occupancy  output  clog2(p_depth+1)  number of valid stages

## Operation
- Each stage i holds val[i], dom[i], data[i]. Stage 0 is at the input and stage p_depth-1 at the output.
- Stage i advances, moving its entry to stage i+1, when val[i] && !val[i+1] or when stage i+1 advances. The last stage advances when out_val && out_rdy.
- in_rdy = !val[0] || stage 0 advances. The ready chain is combinational through all stages, so throughput is 1 message/cycle.
- Kill rule: when flush is high, every entry with dom == flush_domain is killed this cycle.
  - A killed stage has val cleared, data set to p_reset_value and dom set to 0.
  - A killed entry is never transferred to the next stage.
- out_val = val[last] && !(flush && dom[last] == flush_domain). A killed entry is never presented as valid.
- Same-cycle input vs flush: an input with in_domain == flush_domain in a flush cycle is accepted (in_rdy unaffected) and discarded. It never enters stage 0.
- Entries of the other domain advance normally during a flush cycle and may fill slots vacated by killed entries in that same cycle.
- out_msg and out_domain reflect the last stage unconditionally. The consumer must qualify them with out_val.
- occupancy = popcount(val) after register update, so it is registered.

## Timing
- Reset (reset==0 at a rising edge): all val=0, data=p_reset_value, dom=0, occupancy=0. After reset, in_rdy=1 combinationally and out_val=0.
- Reset overrides any in-flight handshake or flush.
- Latency: a message accepted at edge t into an empty chain appears with out_val=1 after edge t+p_depth-1 (p_depth-1 cycles after acceptance).
- Full: if all val=1 and out_rdy=0, in_rdy=0. With out_rdy=1 the full chain still accepts 1/cycle.
- Backpressure preserves order. There is no reordering or duplication; a stalled entry holds its data stable.
- Flush takes effect at the same edge: a killed entry is gone from the following cycle. The flush has no effect on entries of the other domain.

## Structure
- Shared package / include `vc-regs.v` gains localparams for domain encodings: DOMAIN_L=0, DOMAIN_H=1.
- One sub-module, `vc_domain_pipe_stage`. It holds one stage (val/dom/data), takes inputs upstream val/dom/data, downstream advance and kill, and outputs its own advance. It is instantiated p_depth times in a generate loop.
- Top level: ready chain, kill decode, out_val masking, occupancy popcount register.

## Test plan
- Reset, then stream 0x11,0x22,0x33 (dom 0), out_rdy=1, p_depth=2 → out_msg order 0x11,0x22,0x33; each appears 1 cycle after acceptance; occupancy never exceeds 2.
- Fill with out_rdy=0 (0xA, 0xB) → in_rdy=0, occupancy=2, out_msg=0xA stable. Then out_rdy=1 → 0xA and 0xB drained in consecutive cycles.
- Chain holds dom 1 (0x5) at stage 0 and dom 0 (0x6) at the last stage. flush=1, flush_domain=1 → next cycle occupancy=1 and stage 0 data=p_reset_value; 0x6 is still delivered.
- Last stage dom 1 with out_rdy=1, flush_domain=1 → out_val=0 that cycle; the consumer never sees the message.
- Flush cycle with in_val=1, in_domain=1, flush_domain=1 → in_rdy=1, message dropped, occupancy unchanged.
- Assert reset mid-stream with a full chain → next cycle occupancy=0, out_val=0, out_msg=p_reset_value.
